// File: rtl/sinfonia_pkg.sv
// Shared note/channel constants, FSM states and the code-to-line helper.
// Also used by the 8-to-3 input-side encoder.
package sinfonia_pkg;

  localparam int unsigned NOTE_W     = 3;
  localparam int unsigned NOTE_LINES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [NOTE_LINES-1:0] onehot_of(
    input logic [NOTE_W-1:0] code
  );
    logic [NOTE_LINES-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_note_driver_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero and flags it.
// Load wins over decrement.
module hold_timer
  import sinfonia_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    priority case (1'b1)
      load_i:                 cnt_d = load_val_i;
      en_i && (cnt_q != '0):  cnt_d = cnt_q - 1'b1;
      default:                cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_note_driver.sv
// Sequential 3-to-8 one-hot driver with a one-deep code buffer.
// Define ONEHOT_GAP_EN for a one-cycle blank between back-to-back codes.
module onehot_note_driver
  import sinfonia_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NOTE_W-1:0]     code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic [NOTE_LINES-1:0] onehot_out,
  output logic                  active,
  output logic                  done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e                  state_q;
  logic [NOTE_LINES-1:0]   onehot_q;
  logic                    active_q;
  logic                    pend_vld_q;
  logic [NOTE_W-1:0]       pend_code_q;

  logic xfer;
  logic expire;
  logic cnt_zero;
  logic t_load;
  logic t_en;

  assign code_ready = ~pend_vld_q;
  assign xfer       = code_valid & code_ready;
  assign expire     = (state_q == HOLD) & cnt_zero;

  always_comb begin
    t_load = 1'b0;
    t_en   = 1'b0;
    unique case (state_q)
      IDLE: t_load = xfer;
      HOLD: begin
        t_en = ~cnt_zero;
`ifdef ONEHOT_GAP_EN
        t_load = 1'b0;
`else
        t_load = cnt_zero & (pend_vld_q | xfer);
`endif
      end
      GAP:  t_load = 1'b1;
      default: begin
        t_load = 1'b0;
        t_en   = 1'b0;
      end
    endcase
  end

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (t_load),
    .load_val_i(RELOAD),
    .en_i      (t_en),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      onehot_q    <= '0;
      active_q    <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            onehot_q <= onehot_of(code_in);
            active_q <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            if (xfer) begin
              pend_vld_q  <= 1'b1;
              pend_code_q <= code_in;
            end
          end else if (pend_vld_q) begin
`ifdef ONEHOT_GAP_EN
            onehot_q <= '0;
            active_q <= 1'b0;
            state_q  <= GAP;
`else
            onehot_q   <= onehot_of(pend_code_q);
            pend_vld_q <= 1'b0;
`endif
          end else if (xfer) begin
`ifdef ONEHOT_GAP_EN
            // The bypassed code parks in the slot for the blank cycle.
            pend_vld_q  <= 1'b1;
            pend_code_q <= code_in;
            onehot_q    <= '0;
            active_q    <= 1'b0;
            state_q     <= GAP;
`else
            onehot_q <= onehot_of(code_in);
`endif
          end else begin
            onehot_q <= '0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        GAP: begin
          onehot_q   <= onehot_of(pend_code_q);
          active_q   <= 1'b1;
          pend_vld_q <= 1'b0;
          state_q    <= HOLD;
        end
        default: begin
          onehot_q <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign onehot_out = onehot_q;
  assign active     = active_q;
  assign done       = expire;

endmodule

// File: tb/tb_onehot_note_driver.sv
// Bench for onehot_note_driver: directed scenarios plus random traffic
// against a queue/remaining-time model of the note schedule.
module tb_onehot_note_driver;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] onehot_out;
  logic       active;
  logic       done;

  int checks;
  int failures;

  // Model: accepted-but-not-playing codes, currently playing code.
  int q[$];
  bit cur_act;
  int cur;
  int rem;
  bit last_xfer;

  int done_cnt;
  int act_cnt;
  int hot20_cnt;

  onehot_note_driver #(
    .HOLD_CYCLES(H),
    .CNT_W      (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .onehot_out(onehot_out),
    .active    (active),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int c);
    bit retire;
    last_xfer = 1'b0;
    if (!r) begin
      q.delete();
      cur_act = 1'b0;
      rem     = 0;
      return;
    end
    last_xfer = v && (q.size() == 0);
    retire    = cur_act && (rem == 1);
    if (last_xfer) q.push_back(c);
    if (cur_act && !retire) begin
      rem--;
`ifdef ONEHOT_GAP_EN
    end else if (retire && q.size() != 0) begin
      cur_act = 1'b0;
`endif
    end else begin
      cur_act = 1'b0;
      if (q.size() != 0) begin
        cur     = q.pop_front();
        cur_act = 1'b1;
        rem     = H;
      end
    end
  endtask

  task automatic compare();
    logic [7:0] exp_hot;
    exp_hot = cur_act ? (8'd1 << cur) : 8'd0;
    check("onehot", onehot_out, exp_hot);
    check("active", active, cur_act);
    check("done", done, cur_act && (rem == 1));
    check("ready", code_ready, q.size() == 0);
    check("popcnt", $countones(onehot_out) <= 1, 1);
    check("zero_iff_idle", onehot_out == 8'd0, !active);
    if (done === 1'b1) done_cnt++;
    if (active === 1'b1) act_cnt++;
    if (onehot_out === 8'h20) hot20_cnt++;
  endtask

  task automatic cycle(input bit v, input int c, input bit r);
    rst_n      = r;
    code_valid = v;
    code_in    = 3'(c);
    @(posedge clk);
    model_edge(r, v, c);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1);
  endtask

  initial begin
    bit hv;
    int hc;
    int tries;
    checks     = 0;
    failures   = 0;
    cur_act    = 1'b0;
    cur        = 0;
    rem        = 0;
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code_in    = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    // Single code 5: line 0x20 for exactly H cycles.
    hot20_cnt = 0;
    done_cnt  = 0;
    cycle(1, 5, 1);
    idle(6);
    check("hold_len_5", hot20_cnt, H);
    check("done_once_5", done_cnt, 1);

    // Code 2 then 7 back-to-back through the pending slot.
    done_cnt = 0;
    cycle(1, 2, 1);
    cycle(1, 7, 1);
    idle(10);
    check("done_two", done_cnt, 2);

    // Code 3 offered exactly in the expiry cycle (bypass).
    cycle(1, 1, 1);
    idle(3);
    cycle(1, 3, 1);
    idle(6);

    // Reset during second hold cycle of code 6 with a code pending.
    done_cnt = 0;
    cycle(1, 6, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    idle(6);
    check("no_done_reset", done_cnt, 0);

    // Sweep 0..7 with valid held until accepted.
    done_cnt = 0;
    act_cnt  = 0;
    for (int k = 0; k < 8; k++) begin
      tries = 0;
      do begin
        cycle(1, k, 1);
        tries++;
      end while (!last_xfer && tries < 20);
      check("sweep_accept", last_xfer, 1);
    end
    tries = 0;
    while (active === 1'b1 && tries < 100) begin
      cycle(0, 0, 1);
      tries++;
    end
    check("sweep_drained", active, 0);
    check("sweep_done", done_cnt, 8);
    check("sweep_active", act_cnt, 32);

    // Random traffic obeying the no-withdraw rule.
    hv = 0;
    hc = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        hv = 0;
        cycle(0, 0, 0);
      end else begin
        if (!(hv && !last_xfer)) begin
          hv = ($urandom_range(0, 9) < 4);
          hc = $urandom_range(0, 7);
        end
        cycle(hv, hc, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
